// File: rtl/register_bank_pkg.sv
// Shared definitions for the register bank: operation codes and read-select sizing.
package register_bank_pkg;

   typedef enum logic [2:0] {
      FUN_DEC          = 3'b000,
      FUN_INC          = 3'b001,
      FUN_LOAD         = 3'b010,
      FUN_CLR          = 3'b011,
      FUN_LOAD_LO_CLR  = 3'b100,
      FUN_LOAD_LO_KEEP = 3'b101,
      FUN_SHL          = 3'b110,
      FUN_ASR          = 3'b111
   } fun_e;

   // Read selects stay at least one bit wide even for tiny banks.
   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/register_cell.sv
// One register slice: storage, function unit, overflow detect and sticky overflow flag.
module register_cell
   import register_bank_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int SATURATE = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  fun_e             fun_sel,
   input  logic [WIDTH-1:0] data_in,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] q,
   output logic             ovf
);

   localparam int HALF = WIDTH / 2;
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] nxt;
   logic             ovf_evt;

   always_comb begin
      nxt     = q;
      ovf_evt = 1'b0;
      case (fun_sel)
         FUN_DEC: begin
            if (q == '0) begin
               ovf_evt = 1'b1;
               nxt     = (SATURATE != 0) ? '0 : '1;
            end else begin
               nxt = q - ONE;
            end
         end
         FUN_INC: begin
            if (q == '1) begin
               ovf_evt = 1'b1;
               nxt     = (SATURATE != 0) ? '1 : '0;
            end else begin
               nxt = q + ONE;
            end
         end
         FUN_LOAD:         nxt = data_in;
         FUN_CLR:          nxt = '0;
         FUN_LOAD_LO_CLR:  nxt = {{(WIDTH - HALF){1'b0}}, data_in[HALF-1:0]};
         FUN_LOAD_LO_KEEP: nxt = {q[WIDTH-1:HALF], data_in[HALF-1:0]};
         FUN_SHL:          nxt = {q[WIDTH-2:0], 1'b0};
         FUN_ASR:          nxt = {q[WIDTH-1], q[WIDTH-1:1]};
         default:          nxt = q;
      endcase
   end

   // A fresh overflow outranks a clear on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q   <= '0;
         ovf <= 1'b0;
      end else begin
         if (en) begin
            q <= nxt;
         end
         if (en && ovf_evt) begin
            ovf <= 1'b1;
         end else if (clr_ovf) begin
            ovf <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/register_bank.sv
// Bank of NUM_REGS independently enabled registers with two combinational read ports.
module register_bank
   import register_bank_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int NUM_REGS = 4,
   parameter int SATURATE = 0
) (
   input  logic                             Clock,
   input  logic                             Reset,
   input  logic [WIDTH-1:0]                 I,
   input  logic [NUM_REGS-1:0]              RegSel,
   input  logic [2:0]                       FunSel,
   input  logic                             ClrOvf,
   input  logic [sel_width(NUM_REGS)-1:0]   OutASel,
   input  logic [sel_width(NUM_REGS)-1:0]   OutBSel,
   output logic [WIDTH-1:0]                 OutA,
   output logic [WIDTH-1:0]                 OutB,
   output logic [NUM_REGS-1:0]              Ovf,
   output logic [NUM_REGS-1:0]              Zero
);

   logic [WIDTH-1:0] regs [NUM_REGS];
   fun_e             fun;

   assign fun = fun_e'(FunSel);

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
      register_cell #(
         .WIDTH    (WIDTH),
         .SATURATE (SATURATE)
      ) u_cell (
         .clk     (Clock),
         .rst_n   (Reset),
         .en      (RegSel[g]),
         .fun_sel (fun),
         .data_in (I),
         .clr_ovf (ClrOvf),
         .q       (regs[g]),
         .ovf     (Ovf[g])
      );

      assign Zero[g] = (regs[g] == '0);
   end

   // Selects beyond the populated registers fall through to zero.
   always_comb begin
      OutA = '0;
      OutB = '0;
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
         if (32'(OutASel) == k) OutA = regs[k];
         if (32'(OutBSel) == k) OutB = regs[k];
      end
   end

endmodule

// File: tb/tb_register_bank.sv
// Randomised and directed check of register_bank against an arithmetic reference model.
module tb_register_bank;
   import register_bank_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] data;
   logic [3:0]  reg_sel;
   logic [2:0]  fun_sel;
   logic        clr_ovf;
   logic [1:0]  sel_a, sel_b;
   logic [15:0] out_a0, out_b0, out_a1, out_b1;
   logic [3:0]  ovf0, zero0;
   logic [2:0]  ovf1, zero1;

   int unsigned m0 [4];
   int unsigned m1 [3];
   bit          o0 [4];
   bit          o1 [3];
   int          n_vec = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   // Wrapping bank, four registers.
   register_bank #(.WIDTH(16), .NUM_REGS(4), .SATURATE(0)) u_dut0 (
      .Clock(clk), .Reset(rst_n), .I(data), .RegSel(reg_sel), .FunSel(fun_sel),
      .ClrOvf(clr_ovf), .OutASel(sel_a), .OutBSel(sel_b), .OutA(out_a0),
      .OutB(out_b0), .Ovf(ovf0), .Zero(zero0)
   );

   // Clamping bank, three registers so select 3 is out of range.
   register_bank #(.WIDTH(16), .NUM_REGS(3), .SATURATE(1)) u_dut1 (
      .Clock(clk), .Reset(rst_n), .I(data), .RegSel(reg_sel[2:0]), .FunSel(fun_sel),
      .ClrOvf(clr_ovf), .OutASel(sel_a), .OutBSel(sel_b), .OutA(out_a1),
      .OutB(out_b1), .Ovf(ovf1), .Zero(zero1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int unsigned next_val(input int unsigned v, input int fun,
                                            input int unsigned d, input bit sat,
                                            output bit ov);
      ov = 1'b0;
      case (fun)
         0: begin
            if (v == 0) begin
               ov = 1'b1;
               return sat ? 0 : 32'hFFFF;
            end
            return v - 1;
         end
         1: begin
            if (v == 32'hFFFF) begin
               ov = 1'b1;
               return sat ? 32'hFFFF : 0;
            end
            return v + 1;
         end
         2: return d & 32'hFFFF;
         3: return 0;
         4: return d & 32'h00FF;
         5: return (v & 32'hFF00) | (d & 32'h00FF);
         6: return (v * 2) % 65536;
         7: return (v / 2) + (v & 32'h8000);
         default: return v;
      endcase
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < 4; k++) begin m0[k] = 0; o0[k] = 1'b0; end
      for (int k = 0; k < 3; k++) begin m1[k] = 0; o1[k] = 1'b0; end
   endfunction

   function automatic void model_edge(input logic [3:0] rs, input logic [2:0] f,
                                      input logic [15:0] d, input logic clr);
      bit ov;
      for (int k = 0; k < 4; k++) begin
         ov = 1'b0;
         if (rs[k]) m0[k] = next_val(m0[k], int'(f), 32'(d), 1'b0, ov);
         if (ov) o0[k] = 1'b1;
         else if (clr) o0[k] = 1'b0;
      end
      for (int k = 0; k < 3; k++) begin
         ov = 1'b0;
         if (rs[k]) m1[k] = next_val(m1[k], int'(f), 32'(d), 1'b1, ov);
         if (ov) o1[k] = 1'b1;
         else if (clr) o1[k] = 1'b0;
      end
   endfunction

   function automatic logic [31:0] rd0(input int s);
      return (s < 4) ? 32'(m0[s]) : 32'h0;
   endfunction

   function automatic logic [31:0] rd1(input int s);
      return (s < 3) ? 32'(m1[s]) : 32'h0;
   endfunction

   task automatic check_all();
      logic [3:0] ez0, eo0;
      logic [2:0] ez1, eo1;
      int a, b;
      for (int s = 0; s < 5; s++) begin
         a = (s < 4) ? s : int'($urandom_range(0, 3));
         b = (s < 4) ? 3 - s : a;
         sel_a = 2'(a);
         sel_b = 2'(b);
         #1;
         chk("outa_w", 32'(out_a0), rd0(a));
         chk("outb_w", 32'(out_b0), rd0(b));
         chk("outa_s", 32'(out_a1), rd1(a));
         chk("outb_s", 32'(out_b1), rd1(b));
      end
      for (int k = 0; k < 4; k++) begin
         ez0[k] = (m0[k] == 0);
         eo0[k] = o0[k];
      end
      for (int k = 0; k < 3; k++) begin
         ez1[k] = (m1[k] == 0);
         eo1[k] = o1[k];
      end
      chk("zero_w", 32'(zero0), 32'(ez0));
      chk("ovf_w",  32'(ovf0),  32'(eo0));
      chk("zero_s", 32'(zero1), 32'(ez1));
      chk("ovf_s",  32'(ovf1),  32'(eo1));
   endtask

   task automatic step(input logic [3:0] rs, input logic [2:0] f,
                       input logic [15:0] d, input logic clr);
      reg_sel = rs;
      fun_sel = f;
      data    = d;
      clr_ovf = clr;
      @(posedge clk);
      model_edge(rs, f, d, clr);
      #1;
      check_all();
   endtask

   // Reset pulsed between edges while an increment is being applied.
   task automatic pulse_reset();
      reg_sel = 4'hF;
      fun_sel = FUN_INC;
      clr_ovf = 1'b0;
      @(posedge clk);
      model_edge(reg_sel, fun_sel, data, clr_ovf);
      #1;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      chk("rst_ovf_w", 32'(ovf0), 32'h0);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      model_edge(reg_sel, fun_sel, data, clr_ovf);
      #1;
      check_all();
   endtask

   task automatic peek_a0(input string tag, input logic [1:0] s, input logic [15:0] exp);
      sel_a = s;
      #1;
      chk(tag, 32'(out_a0), 32'(exp));
   endtask

   initial begin
      logic [3:0]  rs;
      logic [2:0]  f;
      logic [15:0] d;
      logic        clr;

      rst_n   = 1'b0;
      data    = '0;
      reg_sel = '0;
      fun_sel = '0;
      clr_ovf = 1'b0;
      sel_a   = '0;
      sel_b   = '0;
      model_reset();
      #2;
      check_all();
      chk("rst_zero_w", 32'(zero0), 32'hF);
      @(negedge clk);
      rst_n = 1'b1;

      step(4'b0001, FUN_LOAD, 16'h0072, 1'b0);
      peek_a0("load_r0", 2'd0, 16'h0072);
      chk("load_zero", 32'(zero0), 32'b1110);

      step(4'b0001, FUN_LOAD, 16'h0025, 1'b0);
      step(4'b0001, FUN_DEC,  16'h0000, 1'b0);
      peek_a0("dec_r0", 2'd0, 16'h0024);
      step(4'b0001, FUN_INC,  16'h0000, 1'b0);
      step(4'b0001, FUN_INC,  16'h0000, 1'b0);
      step(4'b0000, FUN_INC,  16'h0000, 1'b0);
      peek_a0("hold_r0", 2'd0, 16'h0026);

      step(4'b0010, FUN_LOAD, 16'hFFFF, 1'b0);
      step(4'b0010, FUN_INC,  16'h0000, 1'b0);
      peek_a0("wrap_r1", 2'd1, 16'h0000);
      chk("wrap_ovf", 32'(ovf0[1]), 32'h1);
      chk("sat_r1", 32'(u_dut1.OutA), 32'(16'hFFFF));
      step(4'b0000, FUN_INC,  16'h0000, 1'b1);
      chk("clr_ovf", 32'(ovf0[1]), 32'h0);

      step(4'b1111, FUN_CLR, 16'h0000, 1'b0);
      chk("clr_zero", 32'(zero0), 32'hF);
      step(4'b0100, FUN_LOAD,         16'hABCD, 1'b0);
      step(4'b0100, FUN_LOAD_LO_KEEP, 16'h1234, 1'b0);
      peek_a0("lo_keep", 2'd2, 16'hAB34);
      step(4'b0100, FUN_LOAD_LO_CLR,  16'h1234, 1'b0);
      peek_a0("lo_clr", 2'd2, 16'h0034);
      step(4'b0100, FUN_LOAD,         16'h8002, 1'b0);
      step(4'b0100, FUN_ASR,          16'h0000, 1'b0);
      peek_a0("asr", 2'd2, 16'hC001);
      step(4'b0100, FUN_SHL,          16'h0000, 1'b0);
      peek_a0("shl", 2'd2, 16'h8002);

      step(4'b1000, FUN_DEC, 16'h0000, 1'b1);
      peek_a0("dec_under", 2'd3, 16'hFFFF);
      chk("under_ovf", 32'(ovf0[3]), 32'h1);

      pulse_reset();

      for (int n = 0; n < 400; n++) begin
         rs = 4'($urandom);
         f  = 3'($urandom);
         case ($urandom_range(0, 4))
            0:       d = 16'h0000;
            1:       d = 16'hFFFF;
            2:       d = 16'hFFFE;
            3:       d = 16'h0001;
            default: d = 16'($urandom);
         endcase
         clr = ($urandom_range(0, 3) == 0);
         step(rs, f, d, clr);
         if ($urandom_range(0, 49) == 0) pulse_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
